// File: rtl/ram_arbiter_2port_if.sv
// Requester-side port of the two-port RAM arbiter: one single-cycle request,
// held until the one-cycle done pulse, plus the per-port read-data register.
interface ram_arbiter_2port_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input done, rdata);
  modport slave  (input req, we, addr, wdata, output done, rdata);
endinterface

// File: rtl/ram_arbiter_2port.sv
// Round-robin two-port sequencer for a latch-based RAM: writes use setup/strobe/hold
// so the latches never see address or data move while the write enable is high.
module ram_arbiter_2port #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  ram_arbiter_2port_if.slave     p0,
  ram_arbiter_2port_if.slave     p1,
  output logic [7:0]             ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_is_write,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic                   busy
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CAPTURE} state_t;

  logic [1:0]             req, we_in;
  logic [1:0][ADDR_W-1:0] addr_in;
  logic [1:0][DATA_W-1:0] wdata_in;

  assign req      = {p1.req, p0.req};
  assign we_in    = {p1.we, p0.we};
  assign addr_in  = {p1.addr, p0.addr};
  assign wdata_in = {p1.wdata, p0.wdata};

  state_t                 state_q, state_d;
  logic                   gnt_q, gnt_d, last_q, last_d;
  logic                   we_q, we_d, wr_q, wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [1:0]             done_q, done_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]             cand;
  logic                   sel;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = '0;
    wr_d    = 1'b0;
    // A port's request is not a candidate in the cycle its own done is showing.
    cand    = req & ~done_q;
    sel     = (&cand) ? ~last_q : cand[1];
    case (state_q)
      IDLE: if (|cand) begin
        gnt_d   = sel;
        last_d  = sel;
        we_d    = we_in[sel];
        addr_d  = addr_in[sel];
        wdata_d = wdata_in[sel];
        state_d = SETUP;
      end
      SETUP: begin
        wr_d    = we_q;
        state_d = we_q ? STROBE : CAPTURE;
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        done_d[gnt_q] = 1'b1;
        state_d       = IDLE;
      end
      CAPTURE: begin
        rdata_d[gnt_q] = ram_rdata;
        done_d[gnt_q]  = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_addr     = {{(8-ADDR_W){1'b0}}, addr_q};
  assign ram_wdata    = wdata_q;
  assign ram_is_write = wr_q;
  assign busy         = (state_q != IDLE);
  assign p0.done      = done_q[0];
  assign p1.done      = done_q[1];
  assign p0.rdata     = rdata_q[0];
  assign p1.rdata     = rdata_q[1];
endmodule

// File: doc/ram_arbiter_2port.md
# ram_arbiter_2port

Sequencer and two-port arbiter for the 64-word × 32-bit latch-based data RAM. Converts single-cycle requests from two requesters (port 0: fetch, port 1: load/store) into a glitch-free, level-sensitive RAM access. Writes use a setup/strobe/hold sequence so the transparent latches never see address or data change while the write enable is high. Round-robin arbitration shares the RAM fairly; the block sits between the core's memory stage and the RAM instance.

## Interface
- ADDR_W, 6, word-address width used by the RAM (64 words).
- DATA_W, 32, data width.

- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- p0_req  in  1  port 0 request; held high with fields stable until p0_done.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_done  out  1  one-cycle completion pulse for port 0.
- p0_rdata  out  DATA_W  port 0 read data; valid from p0_done, held until the next port 0 read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_rdata: same as port 0, for port 1.
- ram_addr  out  8  RAM address; bits [7:ADDR_W] always 0.
- ram_wdata  out  DATA_W  RAM write data.
- ram_is_write  out  1  RAM write enable, driven straight from a flop.
- ram_rdata  in  DATA_W  RAM read data (combinational from ram_addr).
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, CAPTURE.
- IDLE: the candidate set is the ports with req=1 and done=0 in this cycle. A port's req is ignored in the cycle its own done is high.
  - One candidate: grant it.
  - Both candidates: grant the port not in last_grant.
  - On grant, register port id, we, addr, wdata; set last_grant; next state is SETUP.
- SETUP: ram_addr and ram_wdata are driven from the registered fields; ram_is_write=0. Next state is STROBE if we=1, else CAPTURE.
- STROBE: ram_is_write=1; address and data unchanged. Next state is HOLD.
- HOLD: ram_is_write=0; address and data still unchanged. Next state is IDLE; set the granted port's done for the next cycle.
- CAPTURE: at the end of the cycle, ram_rdata is registered into the granted port's rdata. Next state is IDLE; set that port's done for the next cycle.
- ram_addr and ram_wdata change only on the edge entering SETUP. They keep their last value in IDLE.
- Write data is never visible on rdata. A write does not update either rdata register.
- Both ports may target the same address. Accesses are serialized in grant order, so a read granted after a write returns the new data.

## Timing
- Request first seen high in IDLE at cycle 0.
  - Read: SETUP at cycle 1, CAPTURE at cycle 2, done and valid rdata at cycle 3. Latency is 3.
  - Write: SETUP at cycle 1, STROBE at cycle 2, HOLD at cycle 3, done at cycle 4. Latency is 4.
- ram_is_write is high for exactly one cycle per write, and never in IDLE, SETUP, HOLD or CAPTURE.
- Back-to-back: the cycle carrying done is IDLE and may grant the other port. Throughput is one read per 3 cycles or one write per 4 cycles.
- Reset values, applied at the first edge with reset=1:
  - state=IDLE, busy=0, ram_is_write=0.
  - ram_addr=0, ram_wdata=0.
  - p0/p1_done=0, p0/p1_rdata=0.
  - last_grant=1, so port 0 wins the first contention.
- Reset mid-access: the access is abandoned with no done pulse. If reset hits during STROBE, ram_is_write drops at that edge and the target word is undefined. A requester still holding req after reset is re-arbitrated as a new request.
- A req that drops before done is a protocol violation; the access still completes and done still pulses.

## Test plan
- Reset, then p0 write addr 5 data 0xDEADBEEF. Required: ram_is_write high only in cycle 2, ram_addr=5 during cycles 1–3, p0_done at cycle 4.
- p0 read addr 5 after that write. Required: p0_rdata=0xDEADBEEF with p0_done at cycle 3; p1_rdata stays 0.
- p0 and p1 request in the same cycle (p0 read addr 1, p1 read addr 2), both held. Required: p0 served first; p1 granted in the cycle of p0_done; p1_done 3 cycles after that.
- Both ports held requesting continuously for 6 accesses. Required: grants alternate 0,1,0,1,0,1; no port served twice in a row while the other waits.
- p1 write addr 63 data 0x12345678, then p0 read addr 63. Required: ram_addr=0x3F, p0_rdata=0x12345678.
- Assert reset during STROBE of a write. Required: next cycle state=IDLE, ram_is_write=0, no done pulse; the held req is re-served with full write latency.
